// File: rtl/alu_pkg.sv
// Shared opcode/state types and decode helpers for the ALU sequencing controller.
package alu_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [3:0] {
    IADD = 4'b0000,
    ISUB = 4'b0001,
    IMUL = 4'b0010,
    IDIV = 4'b0011,
    IREM = 4'b0100,
    INEG = 4'b0101,
    IOR  = 4'b1000,
    IXOR = 4'b1001,
    ISHL = 4'b1100,
    ISHR = 4'b1101,
    IAND = 4'b1111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // Opcodes 0110, 0111, 1010, 1011 and 1110 are undefined.
  function automatic logic op_is_legal(input logic [3:0] op);
    logic legal;
    case (op)
      IADD, ISUB, IMUL, IDIV, IREM, INEG,
      IOR, IXOR, ISHL, ISHR, IAND: legal = 1'b1;
      default:                     legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == IDIV) || (op == IREM);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU for every non-divide opcode.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] amt;
  logic [31:0]    prod;

  assign amt  = b[SHW-1:0];
  assign prod = {16'b0, a[15:0]} * {16'b0, b[15:0]};

  // Opcode decode; divide and undefined opcodes yield zero here.
  always_comb begin
    y = '0;
    case (alu_op_t'(op))
      IADD:    y = a + b;
      ISUB:    y = a - b;
      IMUL:    y = WIDTH'(prod);
      INEG:    y = ~a;
      ISHL:    y = a << amt;
      ISHR:    y = a >> amt;
      IAND:    y = a & b;
      IOR:     y = a | b;
      IXOR:    y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl_div_iter.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, W cycles.
// done is a single-cycle pulse after the last iteration; outputs hold until
// the next start.
module div_iter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic          active;
  logic [W:0]    shifted;
  logic [W:0]    diff;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    shifted = {remainder, quotient[W-1]};
    diff    = shifted - {1'b0, dvs};
  end

  // Load on start, then shift in one quotient bit per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvs       <= '0;
      cnt       <= '0;
      active    <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        remainder <= '0;
        quotient  <= dividend;
        dvs       <= divisor;
        cnt       <= '0;
        active    <= 1'b1;
      end else if (active) begin
        remainder <= diff[W] ? shifted[W-1:0] : diff[W-1:0];
        quotient  <= {quotient[W-2:0], ~diff[W]};
        cnt       <= cnt + CW'(1);
        if (cnt == CW'(W - 1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller in front of the integer ALU: one op per request,
// registered result, IDIV/IREM routed through the iterative divider.
//
// Handshakes: a request is accepted on a rising edge where req_valid and
// req_ready are both high (req_ready is high only in IDLE); a response is
// consumed on a rising edge where resp_valid and resp_ready are both high,
// and result/flags hold steady for as long as resp_valid waits on resp_ready.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       op_select,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             illegal_op,
  output logic             busy,
  output seq_state_t       fsm_state
);

  seq_state_t           state, state_next;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [WIDTH-1:0]     alu_y;
  logic                 div_start, div_done;
  logic [DIV_WIDTH-1:0] quo, rem;
  logic                 accept, handshake;
  logic                 req_is_div, req_dbz, req_illegal;

  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign fsm_state   = state;
  assign accept      = req_valid & req_ready;
  assign handshake   = resp_valid & resp_ready;
  assign req_is_div  = op_is_div(op_select);
  assign req_dbz     = req_is_div && (operand_b[DIV_WIDTH-1:0] == '0);
  assign req_illegal = !op_is_legal(op_select);

  alu #(.WIDTH(WIDTH)) u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

  div_iter #(.W(DIV_WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (operand_a[DIV_WIDTH-1:0]),
    .divisor   (operand_b[DIV_WIDTH-1:0]),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

  // State register; resp_valid rises one cycle after entering DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
    end else begin
      state      <= state_next;
      resp_valid <= (state == DONE) && !handshake;
    end
  end

  // Next-state decode; the divider is started directly from the request.
  always_comb begin
    state_next = state;
    div_start  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_illegal || req_dbz) begin
            state_next = DONE;
          end else if (req_is_div) begin
            state_next = DIV;
            div_start  = 1'b1;
          end else begin
            state_next = EXEC;
          end
        end
      end
      EXEC:    state_next = DONE;
      DIV:     if (div_done) state_next = DONE;
      DONE:    if (handshake) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, result capture and response flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else if (accept) begin
      op_q        <= op_select;
      a_q         <= operand_a;
      b_q         <= operand_b;
      result      <= '0;
      div_by_zero <= req_dbz;
      illegal_op  <= req_illegal;
    end else if (state == EXEC) begin
      result <= alu_y;
    end else if ((state == DIV) && div_done) begin
      result <= {{(WIDTH-DIV_WIDTH){1'b0}}, (op_q == IDIV) ? quo : rem};
    end else if (handshake) begin
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: latency, results, flags, stall and reset.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  op_select;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] result;
  logic        div_by_zero;
  logic        illegal_op;
  logic        busy;
  seq_state_t  fsm_state;

  int checks = 0;
  int errors = 0;

  alu_seq_ctrl #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .op_select   (op_select),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .result      (result),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op),
    .busy        (busy),
    .fsm_state   (fsm_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks: all called at posedge+1
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    op_select = op;
    operand_a = a;
    operand_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Counts rising edges after the accept edge until resp_valid is seen.
  task automatic wait_resp(output int lat);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  // Issue one op and check latency, result, flags and the return to IDLE.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                        input logic exp_dbz, input logic exp_ill);
    int lat;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready before issue: got %b want 1", name, req_ready);
    end
    issue(op, a, b);
    wait_resp(lat);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (result !== exp_res) begin
      errors++;
      $display("FAIL %s result: got %h want %h", name, result, exp_res);
    end
    checks++;
    if (div_by_zero !== exp_dbz || illegal_op !== exp_ill) begin
      errors++;
      $display("FAIL %s flags: got dbz=%b ill=%b want dbz=%b ill=%b",
               name, div_by_zero, illegal_op, exp_dbz, exp_ill);
    end
    consume();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 ||
        div_by_zero !== 1'b0 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL %s after handshake: got rv=%b rr=%b busy=%b dbz=%b ill=%b want 0 1 0 0 0",
               name, resp_valid, req_ready, busy, div_by_zero, illegal_op);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || result !== 32'h0 ||
        div_by_zero !== 1'b0 || illegal_op !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset state: got rr=%b rv=%b res=%h dbz=%b ill=%b busy=%b want 1 0 0 0 0 0",
               req_ready, resp_valid, result, div_by_zero, illegal_op, busy);
    end
  endtask

  task automatic test_add();
    run_op("iadd_5_7", 4'b0000, 32'd5, 32'd7, 2, 32'd12, 1'b0, 1'b0);
  endtask

  task automatic test_div();
    run_op("idiv", 4'b0011, 32'h0001_0064, 32'd7, 18, 32'd14, 1'b0, 1'b0);
    run_op("irem", 4'b0100, 32'h0001_0064, 32'd7, 18, 32'd2, 1'b0, 1'b0);
    run_op("idiv_ffff_1", 4'b0011, 32'h0000_FFFF, 32'h0000_0001, 18, 32'h0000_FFFF, 1'b0, 1'b0);
    run_op("irem_small", 4'b0100, 32'd5, 32'd9, 18, 32'd5, 1'b0, 1'b0);
  endtask

  task automatic test_div_zero();
    run_op("idiv_by_zero", 4'b0011, 32'd9, 32'h0001_0000, 1, 32'd0, 1'b1, 1'b0);
    run_op("irem_by_zero", 4'b0100, 32'd9, 32'd0, 1, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_shift();
    run_op("ishl_1_33", 4'b1100, 32'd1, 32'd33, 2, 32'd2, 1'b0, 1'b0);
    run_op("ishr_msb_31", 4'b1101, 32'h8000_0000, 32'd31, 2, 32'd1, 1'b0, 1'b0);
  endtask

  task automatic test_illegal();
    logic [3:0] codes [5] = '{4'b0110, 4'b0111, 4'b1010, 4'b1011, 4'b1110};
    for (int i = 0; i < 5; i++) begin
      run_op($sformatf("illegal_%b", codes[i]), codes[i], 32'hFFFF_FFFF, 32'h0000_0003,
             1, 32'd0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [6] = '{4'b0001, 4'b0010, 4'b1111, 4'b1000, 4'b0101, 4'b0000};
    logic [31:0] as  [6] = '{32'd3, 32'h0001_FFFF, 32'hFF00_FF00, 32'hF000_0000, 32'h0000_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [6] = '{32'd10, 32'h0000_FFFF, 32'h0F0F_0F0F, 32'h0000_0001, 32'h1234_5678, 32'd1};
    logic [31:0] exp [6] = '{32'hFFFF_FFF9, 32'hFFFE_0001, 32'h0F00_0F00, 32'hF000_0001, 32'hFFFF_0000, 32'h0};
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("b2b_%0d", i), ops[i], as[i], bs[i], 2, exp[i], 1'b0, 1'b0);
    end
  endtask

  task automatic test_stall();
    int lat;
    issue(4'b1001, 32'hF0F0_1234, 32'h0FF0_00FF);
    wait_resp(lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL stall latency: got %0d want 2", lat);
    end
    // A competing request held during DONE must be ignored.
    req_valid = 1'b1;
    op_select = 4'b0000;
    operand_a = 32'd100;
    operand_b = 32'd100;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || result !== 32'hFF00_12CB || req_ready !== 1'b0 ||
          busy !== 1'b1 || illegal_op !== 1'b0 || div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL stall cycle %0d: got rv=%b res=%h rr=%b busy=%b want 1 ff0012cb 0 1",
                 i, resp_valid, result, req_ready, busy);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    consume();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall release: got rv=%b rr=%b want 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_div();
    issue(4'b0011, 32'h0001_0064, 32'd7);
    repeat (7) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_div before reset: got busy=%b rv=%b want 1 0", busy, resp_valid);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || result !== 32'h0 ||
        busy !== 1'b0 || div_by_zero !== 1'b0 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL mid_div async reset: got rr=%b rv=%b res=%h busy=%b want 1 0 0 0",
               req_ready, resp_valid, result, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("iadd_after_reset", 4'b0000, 32'd1, 32'd1, 2, 32'd2, 1'b0, 1'b0);
  endtask

  // test sequence and final report
  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    op_select  = 4'b0000;
    operand_a  = 32'h0;
    operand_b  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_add();
    test_div();
    test_div_zero();
    test_shift();
    test_illegal();
    test_back_to_back();
    test_stall();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
